// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic light controller for NUM_DIR approaches with adjustable
// per-approach green, shared yellow/all-red lengths, night flash and countdown display.
module traffic_ctrl_multi #(
  parameter int NUM_DIR   = 2,
  parameter int TIME_W    = 4,
  parameter int DEFAULT_G = 10,
  parameter int DEFAULT_Y = 3,
  parameter int DEFAULT_R = 2,
  parameter int DB_CYCLES = 65535,
  localparam int DW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic [1:0]             mode_i,
  input  logic [DW-1:0]          dir_sel_i,
  input  logic [2:0]             btn_i,
  input  logic                   flash_i,
  output logic [3*NUM_DIR-1:0]   led_o,
  output logic [TIME_W-1:0]      time_o,
  output logic [DW-1:0]          phase_o
);
  localparam int LW = $clog2(DB_CYCLES + 1);
  localparam logic [2:0] C_RED = 3'b100, C_GRN = 3'b010, C_YEL = 3'b110,
                         C_WHT = 3'b111, C_OFF = 3'b000;
  localparam logic [TIME_W-1:0] T_MAX = '1;

  typedef enum logic [1:0] {GRN, YEL, ARD, FLS} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     phase, phase_nxt, phase_inc;
  logic [TIME_W-1:0] ctime, ctime_nxt;
  logic              blink, blink_nxt;
  logic [TIME_W-1:0] glen [NUM_DIR];
  logic [TIME_W-1:0] ylen, rlen;
  logic [LW-1:0]     lockout;
  logic              dir_ok;
  logic [TIME_W-1:0] cur_len, new_len, disp;

  assign phase_o   = phase;
  assign phase_inc = (phase == DW'(NUM_DIR - 1)) ? '0 : phase + 1'b1;
  assign dir_ok    = ({1'b0, dir_sel_i} < (DW + 1)'(NUM_DIR));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= GRN;
      phase <= '0;
      ctime <= TIME_W'(DEFAULT_G);
      blink <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      ctime <= ctime_nxt;
      blink <= blink_nxt;
    end
  end

  // Sequencing only advances on tick cycles; flash request wins over normal stepping.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ctime_nxt = ctime;
    blink_nxt = blink;
    if (tick_i) begin
      if (flash_i) begin
        state_nxt = FLS;
        blink_nxt = ~blink;
      end else if (state == FLS) begin
        state_nxt = GRN;
        phase_nxt = '0;
        ctime_nxt = glen[0];
        blink_nxt = 1'b0;
      end else if (ctime != '0) begin
        ctime_nxt = ctime - 1'b1;
      end else begin
        case (state)
          GRN: begin
            state_nxt = YEL;
            ctime_nxt = ylen;
          end
          YEL: begin
            state_nxt = ARD;
            ctime_nxt = rlen;
          end
          default: begin
            state_nxt = GRN;
            phase_nxt = phase_inc;
            ctime_nxt = glen[phase_inc];
          end
        endcase
      end
    end
  end

  always_comb begin
    cur_len = '0;
    case (mode_i)
      2'b01:   cur_len = dir_ok ? glen[dir_sel_i] : '0;
      2'b10:   cur_len = ylen;
      2'b11:   cur_len = rlen;
      default: cur_len = '0;
    endcase
    if (btn_i[0])      new_len = TIME_W'(DEFAULT_G);
    else if (btn_i[1]) new_len = (cur_len == T_MAX) ? cur_len : cur_len + 1'b1;
    else               new_len = (cur_len == '0) ? cur_len : cur_len - 1'b1;
    if (mode_i == 2'b10 && btn_i[0]) new_len = TIME_W'(DEFAULT_Y);
    if (mode_i == 2'b11 && btn_i[0]) new_len = TIME_W'(DEFAULT_R);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIR; i++) glen[i] <= TIME_W'(DEFAULT_G);
      ylen    <= TIME_W'(DEFAULT_Y);
      rlen    <= TIME_W'(DEFAULT_R);
      lockout <= '0;
    end else if (lockout != '0) begin
      lockout <= lockout - 1'b1;
    end else if (btn_i != 3'b000) begin
      lockout <= LW'(DB_CYCLES);
      case (mode_i)
        2'b01:   if (dir_ok) glen[dir_sel_i] <= new_len;
        2'b10:   ylen <= new_len;
        2'b11:   rlen <= new_len;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (mode_i)
      2'b00:   disp = (state == FLS) ? '0 : ctime;
      2'b01:   disp = dir_ok ? glen[dir_sel_i] : '0;
      2'b10:   disp = ylen;
      default: disp = rlen;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) time_o <= TIME_W'(DEFAULT_G);
    else       time_o <= disp;
  end

  always_comb begin
    led_o = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (state == FLS) begin
        led_o[3*i +: 3] = blink ? ((i == 0) ? C_YEL : C_RED) : C_OFF;
      end else begin
        case (mode_i)
          2'b00: begin
            if (state == ARD || DW'(i) != phase) led_o[3*i +: 3] = C_RED;
            else led_o[3*i +: 3] = (state == GRN) ? C_GRN : C_YEL;
          end
          2'b01:   led_o[3*i +: 3] = (dir_ok && DW'(i) == dir_sel_i) ? C_GRN : C_RED;
          2'b10:   led_o[3*i +: 3] = C_YEL;
          default: led_o[3*i +: 3] = C_WHT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi (3 approaches, short button lockout) with a
// tick-level behavioural model checked after every clock.
module tb_traffic_ctrl_multi;
  localparam int N  = 3;
  localparam int DB = 4;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst, tick, flash;
  logic [1:0]    mode;
  logic [DW-1:0] dir_sel;
  logic [2:0]    btn;
  logic [3*N-1:0] led;
  logic [3:0]    time_v;
  logic [DW-1:0] phase;

  int total = 0;
  int bad   = 0;

  // model: kind 0 green, 1 yellow, 2 all-red, 3 flash
  int m_kind, m_ph, m_ct, m_yl, m_rl, m_bl, m_lock, m_time;
  int m_gl [N];

  traffic_ctrl_multi #(
    .NUM_DIR(N), .TIME_W(4), .DEFAULT_G(10), .DEFAULT_Y(3), .DEFAULT_R(2), .DB_CYCLES(DB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .mode_i(mode), .dir_sel_i(dir_sel),
    .btn_i(btn), .flash_i(flash), .led_o(led), .time_o(time_v), .phase_o(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int adj(input int v, input int dflt);
    if (btn[0]) return dflt;
    if (btn[1]) return (v >= 15) ? 15 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic int exp_led();
    int r, c;
    r = 0;
    for (int i = 0; i < N; i++) begin
      if (m_kind == 3)       c = m_bl ? ((i == 0) ? 6 : 4) : 0;
      else if (mode == 2'd0) c = (m_kind == 2 || i != m_ph) ? 4 : ((m_kind == 0) ? 2 : 6);
      else if (mode == 2'd1) c = (i == int'(dir_sel)) ? 2 : 4;
      else if (mode == 2'd2) c = 6;
      else                   c = 7;
      r = r | (c << (3 * i));
    end
    return r;
  endfunction

  task automatic model_update();
    int nt, d;
    d = int'(dir_sel);
    if (mode == 2'd0)      nt = (m_kind == 3) ? 0 : m_ct;
    else if (mode == 2'd1) nt = (d < N) ? m_gl[d] : 0;
    else if (mode == 2'd2) nt = m_yl;
    else                   nt = m_rl;
    if (rst) begin
      m_kind = 0; m_ph = 0; m_ct = 10; m_yl = 3; m_rl = 2; m_bl = 0; m_lock = 0;
      for (int i = 0; i < N; i++) m_gl[i] = 10;
      m_time = 10;
      return;
    end
    if (tick) begin
      if (flash) begin
        m_kind = 3; m_bl = 1 - m_bl;
      end else if (m_kind == 3) begin
        m_kind = 0; m_ph = 0; m_ct = m_gl[0]; m_bl = 0;
      end else if (m_ct > 0) begin
        m_ct--;
      end else if (m_kind == 0) begin
        m_kind = 1; m_ct = m_yl;
      end else if (m_kind == 1) begin
        m_kind = 2; m_ct = m_rl;
      end else begin
        m_kind = 0; m_ph = (m_ph + 1) % N; m_ct = m_gl[m_ph];
      end
    end
    if (m_lock > 0) m_lock--;
    else if (btn != 3'b000) begin
      m_lock = DB;
      if (mode == 2'd1 && d < N) m_gl[d] = adj(m_gl[d], 10);
      else if (mode == 2'd2)     m_yl = adj(m_yl, 3);
      else if (mode == 2'd3)     m_rl = adj(m_rl, 2);
    end
    m_time = nt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("led", int'(led), exp_led());
    chk("time", int'(time_v), m_time);
    chk("phase", int'(phase), m_ph);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic hold(input logic [2:0] b, input int n);
    btn = b; steps(n);
    btn = 3'b000; steps(DB + 2);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; flash = 1'b0; mode = 2'd0; dir_sel = '0; btn = 3'b000;
    step();
    rst = 1'b0;
    step();
    chk("rst_time", int'(time_v), 10);
    chk("rst_led", int'(led), 9'b100_100_010);
    chk("rst_phase", int'(phase), 0);

    tk(10);
    chk("grn_hold", int'(led), 9'b100_100_010);
    tk(1);
    chk("yel_led", int'(led), 9'b100_100_110);
    chk("yel_time", int'(time_v), 3);
    chk("model_yel", m_time, 3);

    for (int t = 12; t <= 54; t++) begin
      tk(1);
      if (t == 18) chk("seq_ph1", int'(phase), 1);
      if (t == 36) chk("seq_ph2", int'(phase), 2);
    end
    chk("cycle_ph0", int'(phase), 0);
    chk("cycle_time", int'(time_v), 10);

    mode = 2'd1; dir_sel = 2'd1;
    hold(3'b010, 3 * (DB + 1));
    chk("glen_inc", int'(time_v), 13);
    hold(3'b010, 5 * (DB + 1));
    chk("glen_sat_hi", int'(time_v), 15);
    hold(3'b100, 17 * (DB + 1));
    chk("glen_sat_lo", int'(time_v), 0);
    hold(3'b001, 1);
    chk("glen_restore", int'(time_v), 10);
    dir_sel = 2'd3;
    hold(3'b010, 1);
    chk("bad_dir_led", int'(led), 9'b100_100_100);
    chk("bad_dir_time", int'(time_v), 0);
    mode = 2'd2; steps(2);
    chk("mode_y_led", int'(led), 9'b110_110_110);
    chk("mode_y_time", int'(time_v), 3);
    mode = 2'd3; steps(2);
    chk("mode_r_led", int'(led), 9'b111_111_111);
    chk("mode_r_time", int'(time_v), 2);

    mode = 2'd0;
    tk(3);
    mode = 2'd1; dir_sel = 2'd0;
    hold(3'b100, 5 * (DB + 1));
    chk("glen0_edit", int'(time_v), 5);
    mode = 2'd0; steps(2);
    chk("run_unchanged", int'(time_v), 7);
    tk(51);
    chk("short_ph0", int'(phase), 0);
    chk("short_time", int'(time_v), 5);
    tk(5);
    chk("short_grn", int'(led), 9'b100_100_010);
    tk(1);
    chk("short_yel", int'(led), 9'b100_100_110);

    flash = 1'b1;
    tk(1);
    chk("fls_on", int'(led), 9'b100_100_110);
    tk(1);
    chk("fls_off", int'(led), 0);
    chk("fls_time", int'(time_v), 0);
    tk(1);
    chk("fls_on2", int'(led), 9'b100_100_110);
    flash = 1'b0;
    tk(1);
    chk("fls_exit_led", int'(led), 9'b100_100_010);
    chk("fls_exit_time", int'(time_v), 5);

    tk(6);
    chk("pre_rst_yel", int'(led), 9'b100_100_110);
    rst = 1'b1; tick = 1'b1; btn = 3'b010; mode = 2'd1; dir_sel = 2'd1;
    step();
    rst = 1'b0; tick = 1'b0; btn = 3'b000; mode = 2'd0; dir_sel = 2'd0;
    step();
    chk("rst2_led", int'(led), 9'b100_100_010);
    chk("rst2_time", int'(time_v), 10);
    mode = 2'd1; dir_sel = 2'd1; steps(2);
    chk("rst2_glen1", int'(time_v), 10);
    dir_sel = 2'd0; steps(2);
    chk("rst2_glen0", int'(time_v), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
Parametrised successor to the two-road traffic light controller. Sequences NUM_DIR approaches round-robin (green -> yellow -> all-red -> next approach) and counts down in seconds from a one-cycle tick strobe, all in a single clock domain. Holds a run-time-adjustable green length per approach plus shared yellow and all-red lengths, adjusted with debounced buttons. Adds a night flash mode and drives per-approach RGB LEDs and a countdown display.

Parameters:
NUM_DIR, 2, number of approaches (2..4)
TIME_W, 4, width of countdown and length registers
DEFAULT_G, 10, reset green length (ticks) for every approach
DEFAULT_Y, 3, reset yellow length
DEFAULT_R, 2, reset all-red length
DB_CYCLES, 65535, button lockout after an accepted press (clk cycles)

Ports:
clk_i  in  1  system clock, the only clock
rst_i  in  1  synchronous, active-high reset
tick_i  in  1  one-clk-wide 1 Hz strobe
mode_i  in  2  00 normal, 01 adjust green, 10 adjust yellow, 11 adjust all-red
dir_sel_i  in  DW=max(1,$clog2(NUM_DIR))  approach whose green is adjusted/displayed in mode 01
btn_i  in  3  [0] restore default, [1] +1, [2] -1
flash_i  in  1  night flash request
led_o  out  3*NUM_DIR  {R,G,B} per approach, approach i at [3i+2:3i]
time_o  out  TIME_W  displayed value
phase_o  out  DW  approach currently served

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i). Reset beats every other input in the same cycle.
- Colours: RED=100, GREEN=010, YELLOW=110, WHITE=111, OFF=000.
- FSM states: GRN, YEL, ARD, FLS; register phase (0..NUM_DIR-1).
- Reset values: state=GRN, phase=0, ctime=DEFAULT_G, all glen[i]=DEFAULT_G, ylen=DEFAULT_Y, rlen=DEFAULT_R, blink=0, lockout counter=0 (buttons accepted immediately), time_o=DEFAULT_G, led_o = approach 0 GREEN, others RED.
- Countdown only on cycles with tick_i=1:
  - ctime!=0: decrement.
  - ctime==0, normal sequencing: GRN->YEL loads ylen; YEL->ARD loads rlen; ARD->GRN with phase=(phase+1) mod NUM_DIR, loads glen[new phase].
  - A state therefore lasts len+1 ticks. Length 0 gives 1 tick.
- Length edits never alter the running ctime. They take effect at the next load.
- Flash mode:
  - flash_i=1 at any tick: next state FLS, blink toggles every tick.
  - In FLS: approach 0 shows YELLOW/OFF, the others RED/OFF (colour when blink=1).
  - Tick with flash_i=0 in FLS: state=GRN, phase=0, ctime=glen[0], blink=0.
  - flash_i is sampled only on tick cycles.
- Buttons:
  - While lockout!=0, decrement lockout and ignore buttons.
  - Otherwise, when any button is high: act, then lockout=DB_CYCLES.
  - Priority: btn[0] > btn[1] > btn[2].
  - Target register: mode 01 glen[dir_sel_i], 10 ylen, 11 rlen. Mode 00 or dir_sel_i>=NUM_DIR: no change, but lockout still loads.
  - +1 saturates at 2^TIME_W-1. -1 saturates at 0.
- Display and LEDs:
  - time_o is registered, one-cycle latency. Mode 00 shows ctime (0 in FLS); 01 glen[dir_sel_i]; 10 ylen; 11 rlen.
  - led_o is combinational from state/mode.
  - Mode 00: GRN/YEL give phase approach GREEN/YELLOW, others RED; ARD gives all RED.
  - Mode 01: dir_sel_i approach GREEN, others RED. Mode 10: all YELLOW. Mode 11: all WHITE.
  - FLS overrides the mode display for led_o.
  - Sequencing continues in every adjust mode.
- phase_o equals phase.

Test Plan:
- Reset then 11 ticks (NUM_DIR=2, defaults) -> GRN phase0 holds for ticks 1-10; 11th tick gives YEL, time_o=3 the next cycle.
- Full cycle NUM_DIR=3 -> phase_o sequence 0,1,2,0; each approach GREEN for 11 ticks, YELLOW 4, all-red 3; one cycle=54 ticks.
- Mode 01, dir_sel=1, btn[1] held for 3*DB_CYCLES+3 cycles -> glen[1]=13; at 15, further presses hold 15; btn[2] from 0 holds 0; btn[0] restores 10.
- Edit glen[0] to 5 mid-GRN of phase0 -> current countdown unchanged; next phase0 green lasts 6 ticks.
- flash_i=1 at a tick -> FLS, approach0 alternates 110/000 per tick, others 100/000; drop flash_i -> next tick GRN phase0, ctime=glen[0].
- rst_i asserted in YEL together with tick_i and btn[1] -> next cycle GRN, phase0, ctime=10, lengths defaults, button press not applied.
